// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned SAMPLE_T0  = 7;
    localparam int unsigned SAMPLE_T1  = 8;
    localparam int unsigned SAMPLE_T2  = 9;
    localparam int unsigned DATA_BITS  = 8;

    // 2-of-3 vote used for every bit decision
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with wrap-bit pointers and a registered head word.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rdata
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_q, rd_q, wr_d, rd_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             push_en, pop_en;

    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty   = (wr_q == rd_q);
    assign pop_en  = pop & ~empty;
    // A pop in the same cycle frees the slot a full FIFO needs
    assign push_en = push & (~full | pop_en);

    // Next pointers and next head; a push into an empty FIFO becomes the head directly
    always_comb begin
        rd_d   = rd_q + {{AW{1'b0}}, pop_en};
        wr_d   = wr_q + {{AW{1'b0}}, push_en};
        head_d = mem[rd_d[AW-1:0]];
        if (push_en && (rd_d == wr_q)) begin
            head_d = wdata;
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clock) begin
        if (push_en) begin
            mem[wr_q[AW-1:0]] <= wdata;
        end
    end

    // Pointers and registered head
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_q   <= '0;
            rd_q   <= '0;
            head_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            head_q <= head_d;
        end
    end

    assign rdata = head_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (16x oversampling, majority vote) feeding a byte FIFO.
// Define UART_RX_PARITY_EN for 8E1 frames with a sticky parity-error output.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV   = 27,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       io_rx,
    output logic       io_o_valid,
    output logic [7:0] io_o_data,
    input  logic       io_i_ready,
    output logic       io_o_frame_err,
    output logic       io_o_overrun,
`ifdef UART_RX_PARITY_EN
    output logic       io_o_parity_err,
`endif
    input  logic       io_i_err_clr
);

    localparam logic [15:0] PRESC_MAX = 16'(BAUD_DIV - 1);
    localparam logic [3:0]  T0        = 4'(SAMPLE_T0);
    localparam logic [3:0]  T1        = 4'(SAMPLE_T1);
    localparam logic [3:0]  T2        = 4'(SAMPLE_T2);
    localparam logic [3:0]  T_LAST    = 4'(OVERSAMPLE - 1);
    localparam logic [2:0]  BIT_LAST  = 3'(DATA_BITS - 1);

    logic        rx_meta, rx_sync, rx_prev;
    logic        fall, tick, maj;
    logic [15:0] presc_q;
    rx_state_t   state;
    logic [3:0]  tick_cnt;
    logic [2:0]  bit_cnt;
    logic        s0, s1;
    logic [7:0]  shreg;
    logic        push_q;
    logic        frame_err_q, overrun_q;
    logic        fifo_full, fifo_empty, pop;
`ifdef UART_RX_PARITY_EN
    logic        par_bad_q, parity_err_q;
`endif

    assign fall = rx_prev & ~rx_sync;
    assign tick = (presc_q == PRESC_MAX);
    assign maj  = majority3(s0, s1, rx_sync);
    assign pop  = io_o_valid & io_i_ready;

    // Two-flop synchroniser plus previous value for edge detection; idle line is high
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= io_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Oversample prescaler; realigned to the start edge so ticks are centred on bits
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
        end else if ((state == IDLE) && fall) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 16'd1;
        end
    end

    // Receive FSM with registered push strobe and sticky frame/parity flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            s0          <= 1'b1;
            s1          <= 1'b1;
            shreg       <= '0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            push_q <= 1'b0;
            // Later set assignments below override this clear
            if (io_i_err_clr) begin
                frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_err_q <= 1'b0;
`endif
            end
            if (state == IDLE) begin
                if (fall) begin
                    state    <= START;
                    tick_cnt <= '0;
                end
            end else if (tick) begin
                tick_cnt <= tick_cnt + 4'd1;
                if (tick_cnt == T0) s0 <= rx_sync;
                if (tick_cnt == T1) s1 <= rx_sync;
                if (tick_cnt == T2) begin
                    case (state)
                        START: begin
                            bit_cnt <= '0;
                            if (maj) state <= IDLE;
                        end
                        DATA: shreg <= {maj, shreg[7:1]};
`ifdef UART_RX_PARITY_EN
                        PARITY: par_bad_q <= (maj != ^shreg);
`endif
                        STOP: begin
                            // Leave right after the decision so an early start edge is seen
                            state <= IDLE;
                            if (!maj) frame_err_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            if (par_bad_q) parity_err_q <= 1'b1;
                            if (maj && !par_bad_q) push_q <= 1'b1;
`else
                            if (maj) push_q <= 1'b1;
`endif
                        end
                        default: ;
                    endcase
                end
                if (tick_cnt == T_LAST) begin
                    case (state)
                        START: state <= DATA;
                        DATA: begin
                            if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                        PARITY: state <= STOP;
                        default: ;
                    endcase
                end
            end
        end
    end

    // Sticky overrun: a byte arrives while full and nothing leaves
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else begin
            if (io_i_err_clr) overrun_q <= 1'b0;
            if (push_q && fifo_full && !pop) overrun_q <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_q),
        .wdata (shreg),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .rdata (io_o_data)
    );

    assign io_o_valid     = ~fifo_empty;
    assign io_o_frame_err = frame_err_q;
    assign io_o_overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign io_o_parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo; honours UART_RX_PARITY_EN (8E1 frames).
module tb_uart_rx_fifo;

    localparam int BaudDiv = 4;
    localparam int Depth   = 4;
    localparam int BitClk  = 16 * BaudDiv;
`ifdef UART_RX_PARITY_EN
    localparam int FrameBits = 11;
`else
    localparam int FrameBits = 10;
`endif
    // Cycle (from start-bit launch) in which the stop decision's push reaches the FIFO:
    // 2 sync flops + edge register, then ticks every BaudDiv, stop tick 9 plus one.
    localparam int PushCyc = 3 + BaudDiv * (16 * (FrameBits - 1) + 10);

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       io_rx = 1'b1;
    logic       io_i_ready = 1'b0;
    logic       io_i_err_clr = 1'b0;
    logic       io_o_valid;
    logic [7:0] io_o_data;
    logic       io_o_frame_err;
    logic       io_o_overrun;
`ifdef UART_RX_PARITY_EN
    logic       io_o_parity_err;
`endif

    always #5 clock = ~clock;

    uart_rx_fifo #(
        .BAUD_DIV   (BaudDiv),
        .FIFO_DEPTH (Depth)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .io_rx          (io_rx),
        .io_o_valid     (io_o_valid),
        .io_o_data      (io_o_data),
        .io_i_ready     (io_i_ready),
        .io_o_frame_err (io_o_frame_err),
        .io_o_overrun   (io_o_overrun),
`ifdef UART_RX_PARITY_EN
        .io_o_parity_err(io_o_parity_err),
`endif
        .io_i_err_clr   (io_i_err_clr)
    );

    int         n_checks = 0;
    int         n_fails  = 0;
    int         valid_cycles = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    logic       exp_frame = 1'b0;
    logic       exp_over  = 1'b0;
    logic       exp_par   = 1'b0;
    bit         rand_ready = 1'b0;

    // Consumer-side monitor: records every accepted byte
    always @(negedge clock) begin
        if (!reset) begin
            if (io_o_valid) valid_cycles++;
            if (io_o_valid && io_i_ready) got.push_back(io_o_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            if (rand_ready) io_i_ready = 1'($urandom_range(0, 1));
        end
    endtask

    // Serialise one frame; optionally raise ready for exactly cycle pulse_at.
    // Afterwards the reference model applies the frame's outcome.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip,
                              input int pulse_at);
        logic [10:0] fr;
        logic        par_ok;
        int          c;
        c = 0;
`ifdef UART_RX_PARITY_EN
        fr     = {stop, (^d) ^ par_flip, d, 1'b0};
        par_ok = !par_flip;
`else
        fr     = {1'b1, stop, d, 1'b0};
        par_ok = 1'b1;
`endif
        for (int b = 0; b < FrameBits; b++) begin
            io_rx = fr[b];
            repeat (BitClk) begin
                @(posedge clock);
                #1;
                c++;
                if (rand_ready) io_i_ready = 1'($urandom_range(0, 1));
                if (c == pulse_at) io_i_ready = 1'b1;
                else if (c == pulse_at + 1) io_i_ready = 1'b0;
            end
        end
        io_rx = 1'b1;
        if (!stop) exp_frame = 1'b1;
        if (!par_ok) exp_par = 1'b1;
        if (stop && par_ok) begin
            if (exp_q.size() - got.size() < Depth) exp_q.push_back(d);
            else exp_over = 1'b1;
        end
    endtask

    task automatic compare_all(input string tag);
        check($sformatf("%s_count", tag), got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), {24'd0, got[i]}, {24'd0, exp_q[i]});
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_frame_err"}, io_o_frame_err, exp_frame);
        check({tag, "_overrun"}, io_o_overrun, exp_over);
`ifdef UART_RX_PARITY_EN
        check({tag, "_parity_err"}, io_o_parity_err, exp_par);
`endif
    endtask

    task automatic err_clear();
        io_i_err_clr = 1'b1;
        step(1);
        io_i_err_clr = 1'b0;
        exp_frame = 1'b0;
        exp_over  = 1'b0;
        exp_par   = 1'b0;
        step(1);
    endtask

    initial begin
        int vc0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_valid", io_o_valid, 1'b0);
        check("rst_data", io_o_data, 8'h00);
        check_flags("rst");
        reset = 1'b0;
        step(10);

        // Single byte, always-ready consumer: one-cycle valid pulse
        io_i_ready = 1'b1;
        vc0 = valid_cycles;
        send_frame(8'hA5, 1'b1, 1'b0, -10);
        step(20);
        compare_all("a5");
        check("a5_valid_cycles", valid_cycles - vc0, 1);
        check_flags("a5");

        // Random bytes with random backpressure
        rand_ready = 1'b1;
        repeat (5) send_frame(8'($urandom), 1'b1, 1'b0, -10);
        step(40);
        rand_ready = 1'b0;
        io_i_ready = 1'b1;
        step(20);
        compare_all("rand");
        check_flags("rand");

        // Short low glitch on the idle line is rejected
        io_rx = 1'b0;
        step(20);
        io_rx = 1'b1;
        step(3 * BitClk);
        check("glitch_valid", io_o_valid, 1'b0);
        compare_all("glitch");
        check_flags("glitch");

        // Stop bit low: discarded, sticky frame error, then cleared
        send_frame(8'h3C, 1'b0, 1'b0, -10);
        step(BitClk);
        compare_all("ferr");
        check_flags("ferr");
        err_clear();
        check_flags("ferr_clr");

        // Break: one frame error only, then a normal byte still gets through once
        io_rx = 1'b0;
        step(3 * FrameBits * BitClk);
        exp_frame = 1'b1;
        io_rx = 1'b1;
        step(BitClk);
        check_flags("break");
        send_frame(8'($urandom), 1'b1, 1'b0, -10);
        step(20);
        compare_all("break");
        err_clear();

        // Overrun: Depth+1 bytes with no consumer
        io_i_ready = 1'b0;
        repeat (Depth + 1) send_frame(8'($urandom), 1'b1, 1'b0, -10);
        step(20);
        check_flags("ovr");
        check("ovr_valid", io_o_valid, 1'b1);
        check("ovr_head", io_o_data, exp_q[got.size()]);
        io_i_ready = 1'b1;
        step(20);
        compare_all("ovr");
        check("ovr_drained", io_o_valid, 1'b0);
        err_clear();
        check_flags("ovr_clr");

        // Full FIFO with a pop in the push cycle: both accepted, no overrun
        io_i_ready = 1'b0;
        repeat (Depth) send_frame(8'($urandom), 1'b1, 1'b0, -10);
        send_frame(8'h55, 1'b1, 1'b0, PushCyc);
        step(20);
        check_flags("fullpop");
        io_i_ready = 1'b1;
        step(20);
        compare_all("fullpop");
        check("fullpop_last", got[got.size() - 1], 8'h55);

        // Reset mid-frame with pending data and a set flag
        io_i_ready = 1'b0;
        send_frame(8'($urandom), 1'b1, 1'b0, -10);
        send_frame(8'($urandom), 1'b0, 1'b0, -10);
        step(20);
        check("pre_rst_valid", io_o_valid, 1'b1);
        check_flags("pre_rst");
        io_rx = 1'b0;
        step(BitClk);
        for (int b = 0; b < 4; b++) begin
            io_rx = b[0] ? 1'b1 : 1'b0;
            step(BitClk);
        end
        reset = 1'b1;
        #1;
        check("mid_rst_valid", io_o_valid, 1'b0);
        check("mid_rst_data", io_o_data, 8'h00);
        while (exp_q.size() > got.size()) void'(exp_q.pop_back());
        exp_frame = 1'b0;
        exp_over  = 1'b0;
        exp_par   = 1'b0;
        check_flags("mid_rst");
        io_rx = 1'b1;
        step(3);
        reset = 1'b0;
        step(10);
        io_i_ready = 1'b1;
        send_frame(8'h81, 1'b1, 1'b0, -10);
        step(20);
        compare_all("post_rst");
        check_flags("post_rst");

`ifdef UART_RX_PARITY_EN
        // Bad parity drops the byte; parity and stop failing together set both flags
        send_frame(8'h81, 1'b1, 1'b1, -10);
        step(20);
        compare_all("par");
        check_flags("par");
        send_frame(8'h5A, 1'b0, 1'b1, -10);
        step(20);
        compare_all("par_stop");
        check_flags("par_stop");
        err_clear();
        check_flags("par_clr");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
